lsu_align_ctrl: RTL

- Multi-cycle load/store alignment controller between the MEM pipeline stage and data memory.
- Accepts one load/store request at a time and checks natural alignment.
- Generates lane-aligned address, byte enables and shifted store data, then runs a request/grant/rvalid handshake with memory.
- Returns load data shifted to bit 0 and zero/sign-extended per access size, with a misalignment error flag. Parametrised in data width (32/64).

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_load_ext.sv | 44 ++++
 rtl/lsu_align_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and alignment helper for the load/store alignment controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // off is the low three address bits; each size only looks at the bits it needs.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational lane shift of the raw read word plus zero/sign extension by access size.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]            rdata,
  input  logic [$clog2(DATA_W/8)-1:0]  off,
  input  logic [1:0]                   size,
  input  logic                         sign,
  output logic [DATA_W-1:0]            data
);

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] keep;
  logic              ext;

  always_comb begin
    sh   = rdata >> {off, 3'b000};
    keep = '1;
    ext  = 1'b0;
    case (size)
      SZ_B: begin
        keep = DATA_W'(8'hFF);
        ext  = sign & sh[7];
      end
      SZ_H: begin
        keep = DATA_W'(16'hFFFF);
        ext  = sign & sh[15];
      end
      SZ_W: begin
        keep = DATA_W'(32'hFFFF_FFFF);
        ext  = sign & sh[31];
      end
      default: begin
        keep = '1;
        ext  = 1'b0;
      end
    endcase
    // Bits above the access width take the extension bit; with keep all ones this is a pass-through.
    data = (sh & keep) | ({DATA_W{ext}} & ~keep);
  end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: alignment check, lane steering and a req/gnt/rvalid memory handshake.
module lsu_align_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  state_e            state;
  logic              lat_we;
  logic              lat_sgn;
  logic [1:0]        lat_size;
  logic [OFF_W-1:0]  lat_off;

  logic [OFF_W-1:0]  off;
  logic [BE_W-1:0]   be_calc;
  logic [DATA_W-1:0] wdata_calc;
  logic [DATA_W-1:0] ext_data;
  logic              bad_req;

  assign off        = req_addr[OFF_W-1:0];
  assign wdata_calc = req_wdata << {off, 3'b000};
  assign bad_req    = misaligned(req_size, req_addr[2:0]) || (req_size == SZ_D && DATA_W == 32);

  always_comb begin
    case (req_size)
      SZ_B:    be_calc = BE_W'(1) << off;
      SZ_H:    be_calc = BE_W'(2'b11) << off;
      SZ_W:    be_calc = BE_W'(4'hF) << off;
      default: be_calc = '1;
    endcase
  end

  lsu_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .rdata (mem_rdata),
    .off   (lat_off),
    .size  (lat_size),
    .sign  (lat_sgn),
    .data  (ext_data)
  );

  // req_ready is a flop held low in reset, so it rises on the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      lat_we     <= 1'b0;
      lat_sgn    <= 1'b0;
      lat_size   <= '0;
      lat_off    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            lat_we    <= req_we;
            lat_sgn   <= req_signed;
            lat_size  <= req_size;
            lat_off   <= off;
            if (bad_req) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= ST_ISSUE;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_be    <= be_calc;
              mem_wdata <= wdata_calc;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_rvalid) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= lat_we ? '0 : ext_data;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= lat_we ? '0 : ext_data;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
